imm_pack: RTL and testbench

- Inverse of the datapath immediate extender. Takes a 32-bit constant plus an imm_src format code and produces the 24-bit instruction immediate field.
- Feeding that field back through the extender with the same imm_src must return the original constant.
- Sits in the instruction-build path of the loader/test-program generator as a 2-stage valid/ready pipeline.
- Flags constants that do not fit the selected format and keeps a saturating count of them.

---
 rtl/imm_pack.sv | 123 ++++++++++++
 tb/tb_imm_pack.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
// Module      : imm_pack
// Description : Packs a 32-bit constant into the 24-bit instruction immediate
//               field for a given imm_src format; 2-stage valid/ready pipe
//               with range-error flag and saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_pack #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_value,
  input  logic [1:0]           in_imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [23:0]          out_imm,
  output logic [1:0]           out_imm_src,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr
);

  localparam logic [1:0] c_SRC_10 = 2'd0;
  localparam logic [1:0] c_SRC_12 = 2'd1;
  localparam logic [1:0] c_SRC_20 = 2'd2;

  logic                 r_s1_valid;
  logic [31:0]          r_s1_value;
  logic [1:0]           r_s1_src;
  logic                 r_out_valid;
  logic [23:0]          r_out_imm;
  logic [1:0]           r_out_src;
  logic                 r_out_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [23:0]          w_imm;
  logic                 w_err;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_s1_adv;

  // Encoding is combinational from s1 so the output register is the only one after it.
  always_comb begin
    w_imm = '0;
    w_err = 1'b0;
    case (r_s1_src)
      c_SRC_10: begin
        w_imm = {14'd0, r_s1_value[9:0]};
        w_err = |r_s1_value[31:10];
      end
      c_SRC_12: begin
        w_imm = {12'd0, r_s1_value[11:0]};
        w_err = |r_s1_value[31:12];
      end
      c_SRC_20: begin
        w_imm = {4'd0, r_s1_value[19:0]};
        w_err = |r_s1_value[31:20];
      end
      default: begin
        w_imm = '0;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_s1_adv   = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready   = !r_s1_valid || !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_value <= '0;
      r_s1_src   <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_value <= in_value;
      r_s1_src   <= in_imm_src;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_src   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid <= 1'b1;
      r_out_imm   <= w_imm;
      r_out_src   <= r_s1_src;
      r_out_err   <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle erroring transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (err_clr) begin
      r_err_count <= '0;
    end else if (w_out_fire && r_out_err && !(&r_err_count)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_imm_src = r_out_src;
  assign out_err     = r_out_err;
  assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_pack
// Description : Directed self-checking bench for imm_pack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [1:0]  in_imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_imm;
  logic [1:0]  out_imm_src;
  logic        out_err;
  logic [15:0] err_count;
  logic        err_clr;

  // A narrow-counter twin sees identical stimulus.
  logic        d4_in_ready;
  logic        d4_out_valid;
  logic [23:0] d4_out_imm;
  logic [1:0]  d4_out_imm_src;
  logic        d4_out_err;
  logic [3:0]  err_count4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_pack #(.ERR_CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_imm_src(in_imm_src), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_imm_src(out_imm_src),
    .out_err(out_err), .err_count(err_count), .err_clr(err_clr)
  );

  imm_pack #(.ERR_CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_value(in_value), .in_imm_src(in_imm_src), .out_valid(d4_out_valid),
    .out_ready(out_ready), .out_imm(d4_out_imm), .out_imm_src(d4_out_imm_src),
    .out_err(d4_out_err), .err_count(err_count4), .err_clr(err_clr)
  );

  function automatic logic [31:0] extend(input logic [23:0] imm, input logic [1:0] src);
    case (src)
      2'd0:    extend = {22'd0, imm[9:0]};
      2'd1:    extend = {20'd0, imm[11:0]};
      2'd2:    extend = {12'd0, imm[19:0]};
      default: extend = 32'd0;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_imm_src = '0;
    out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_imm !== 24'h0 || out_imm_src !== 2'd0 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_fields got imm=%h src=%0d err=%b exp 0/0/0", out_imm, out_imm_src, out_err); end
    n_checks++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err_count got %h exp 0", err_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream3(input string name,
                              input logic [31:0] v0, input logic [1:0] s0,
                              input logic [31:0] v1, input logic [1:0] s1,
                              input logic [31:0] v2, input logic [1:0] s2,
                              input logic [23:0] i0, input logic e0,
                              input logic [23:0] i1, input logic e1,
                              input logic [23:0] i2, input logic e2);
    logic [23:0] ei [3];
    logic        ee [3];
    logic [1:0]  es [3];
    ei[0] = i0; ei[1] = i1; ei[2] = i2;
    ee[0] = e0; ee[1] = e1; ee[2] = e2;
    es[0] = s0; es[1] = s1; es[2] = s2;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_value = v0; in_imm_src = s0;
    @(posedge clk); #1;
    in_value = v1; in_imm_src = s1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_latency got out_valid=%b exp 0", name, out_valid); end
    @(posedge clk); #1;
    in_value = v2; in_imm_src = s2;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_imm !== ei[k] || out_err !== ee[k] || out_imm_src !== es[k]) begin
        n_fail++;
        $display("FAIL %s_beat%0d got v=%b imm=%h err=%b src=%0d exp v=1 imm=%h err=%b src=%0d",
                 name, k, out_valid, out_imm, out_err, out_imm_src, ei[k], ee[k], es[k]);
      end
      @(posedge clk); #1;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drain got out_valid=%b exp 0", name, out_valid); end
  endtask

  task automatic test_legal;
    test_stream3("legal", 32'h3FF, 2'd0, 32'hABC, 2'd1, 32'hFFFFF, 2'd2,
                 24'h0003FF, 1'b0, 24'h000ABC, 1'b0, 24'h0FFFFF, 1'b0);
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL legal_err_count got %0d exp 0", err_count); end
  endtask

  task automatic test_range_err;
    test_stream3("rangeerr", 32'h400, 2'd0, 32'h12345, 2'd1, 32'h0, 2'd3,
                 24'h000000, 1'b1, 24'h000345, 1'b1, 24'h000000, 1'b1);
    n_checks++; if (err_count !== 16'd3) begin n_fail++; $display("FAIL rangeerr_count got %0d exp 3", err_count); end
    n_checks++; if (err_count4 !== 4'd3) begin n_fail++; $display("FAIL rangeerr_count4 got %0d exp 3", err_count4); end
  endtask

  task automatic test_back_to_back;
    int in_idx = 0;
    int out_idx = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 5; cyc++) begin
      @(posedge clk); #1;
      out_ready  = (cyc >= 4);
      in_valid   = (in_idx < 5);
      in_value   = 32'h100 + 32'(in_idx);
      in_imm_src = 2'd1;
      #1;
      if (cyc == 2 || cyc == 3) begin
        n_checks++; if (in_ready !== 1'b0 || in_idx != 2) begin
          n_fail++; $display("FAIL bp_full_cyc%0d got in_ready=%b accepted=%0d exp 0/2", cyc, in_ready, in_idx); end
      end
      if (out_valid && !out_ready) begin
        n_checks++; if (out_imm !== 24'h100 + 24'(out_idx) || out_err !== 1'b0) begin
          n_fail++; $display("FAIL bp_hold got imm=%h err=%b exp imm=%h err=0", out_imm, out_err, 24'h100 + 24'(out_idx)); end
      end
      if (out_valid && out_ready) begin
        n_checks++; if (out_imm !== 24'h100 + 24'(out_idx) || out_err !== 1'b0) begin
          n_fail++; $display("FAIL bp_order got imm=%h err=%b exp imm=%h err=0", out_imm, out_err, 24'h100 + 24'(out_idx)); end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (out_idx != 5) begin n_fail++; $display("FAIL bp_timeout got %0d beats exp 5", out_idx); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_saturation;
    @(posedge clk); #1;
    err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_checks++; if (err_count !== 16'd0 || err_count4 !== 4'd0) begin
      n_fail++; $display("FAIL sat_clear got %0d/%0d exp 0/0", err_count, err_count4); end
    in_valid = 1'b1; in_value = 32'h400; in_imm_src = 2'd0;
    repeat (20) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (err_count4 !== 4'hF) begin n_fail++; $display("FAIL sat_count4 got %h exp f", err_count4); end
    n_checks++; if (err_count !== 16'd20) begin n_fail++; $display("FAIL sat_count16 got %0d exp 20", err_count); end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      n_fail++; $display("FAIL sat_pending got v=%b err=%b exp 1/1", out_valid, out_err); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_checks++; if (err_count !== 16'd0 || err_count4 !== 4'd0) begin
      n_fail++; $display("FAIL sat_clr_wins got %0d/%0d exp 0/0", err_count, err_count4); end
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_value = 32'h400; in_imm_src = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (err_count !== 16'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre got cnt=%0d v=%b exp 1/1", err_count, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 16'd0 || err_count4 !== 4'd0) begin
      n_fail++; $display("FAIL arst_immediate got v=%b rdy=%b cnt=%0d/%0d exp 0/1/0/0", out_valid, in_ready, err_count, err_count4); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_value = 32'h55; in_imm_src = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_resume_lat got v=%b exp 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_imm !== 24'h55 || out_err !== 1'b0) begin
      n_fail++; $display("FAIL arst_resume got v=%b imm=%h err=%b exp 1/000055/0", out_valid, out_imm, out_err); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL arst_after got v=%b cnt=%0d exp 0/0", out_valid, err_count); end
  endtask

  task automatic test_round_trip;
    logic [31:0] q_val[$];
    logic [1:0]  q_src[$];
    logic [31:0] v, m, ev;
    logic [1:0]  s;
    int          w;
    int          sent = 0;
    int          got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 30; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        ev = q_val.pop_front(); s = q_src.pop_front();
        w  = (s == 2'd0) ? 10 : (s == 2'd1) ? 12 : 20;
        m  = (32'd1 << w) - 32'd1;
        n_checks++; if (out_imm !== 24'(ev & m) || out_err !== ((ev >> w) != 0) || out_imm_src !== s) begin
          n_fail++; $display("FAIL rt_encode got imm=%h err=%b src=%0d exp imm=%h err=%b src=%0d",
                             out_imm, out_err, out_imm_src, 24'(ev & m), ((ev >> w) != 0), s); end
        if (!out_err) begin
          n_checks++; if (extend(out_imm, out_imm_src) !== ev) begin
            n_fail++; $display("FAIL rt_extend got %h exp %h", extend(out_imm, out_imm_src), ev); end
        end
        got++;
      end
      if (sent < 30) begin
        s = 2'($urandom_range(0, 2));
        w = (s == 2'd0) ? 10 : (s == 2'd1) ? 12 : 20;
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v = v & ((32'd1 << w) - 32'd1);
        in_valid = 1'b1; in_value = v; in_imm_src = s;
        q_val.push_back(v); q_src.push_back(s);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_checks++; if (got != 30) begin n_fail++; $display("FAIL rt_timeout got %0d beats exp 30", got); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_range_err();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
